fifo_button_ctrl: RTL

- Converts two debounced push-button levels (push, pop) into single-cycle FIFO write/read strobes.
- Adds hold-to-repeat with a configurable initial delay and repeat rate, and round-robin arbitration between the two buttons.
- Suppresses strobes when the FIFO is full or empty, and records the attempted overflow or underflow in sticky error flags.
- Sits between the debouncer outputs and the FIFO write/read enables, in the same clock domain as the debouncers.

---
 rtl/fifo_button_ctrl_if.sv | 24 ++
 rtl/fifo_button_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fifo_button_ctrl_if.sv
// Bundles the button, FIFO-flag and strobe signals that pass between the
// debouncer/FIFO side (master) and the button controller (slave).
interface fifo_button_ctrl_if;
    logic       push_btn;
    logic       pop_btn;
    logic       fifo_full;
    logic       fifo_empty;
    logic       err_clr;
    logic       wr_en;
    logic       rd_en;
    logic       ovf_err;
    logic       udf_err;
    logic [1:0] state;

    modport master (
        output push_btn, pop_btn, fifo_full, fifo_empty, err_clr,
        input  wr_en, rd_en, ovf_err, udf_err, state
    );

    modport slave (
        input  push_btn, pop_btn, fifo_full, fifo_empty, err_clr,
        output wr_en, rd_en, ovf_err, udf_err, state
    );
endinterface

// File: rtl/fifo_button_ctrl.sv
// Turns debounced push/pop button levels into single-cycle FIFO strobes with
// hold-to-repeat, round-robin arbitration and sticky overflow/underflow flags.
module fifo_button_ctrl #(
    parameter int REPEAT_DELAY = 2500,
    parameter int REPEAT_RATE  = 500,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_button_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PUSH_HOLD = 2'b01,
        POP_HOLD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    // Channel index 0 is the push side, 1 is the pop side.
    localparam int CH_PUSH = 0;
    localparam int CH_POP  = 1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_pop_reg, last_pop_next;

    logic [1:0] btn;
    logic [1:0] allow;
    logic [1:0] btn_q_reg;
    logic [1:0] rise;
    logic [1:0] fire;
    logic [1:0] strobe_reg, strobe_next;
    logic [1:0] err_reg, err_next;

    assign btn   = {bus.pop_btn, bus.push_btn};
    assign allow = {~bus.fifo_empty, ~bus.fifo_full};

    // A fire that the FIFO flag forbids becomes a sticky error instead of a
    // strobe; setting wins over a simultaneous clear.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            assign rise[gi]        = btn[gi] & ~btn_q_reg[gi];
            assign strobe_next[gi] = fire[gi] & allow[gi];
            assign err_next[gi]    = (fire[gi] & ~allow[gi]) |
                                     (err_reg[gi] & ~bus.err_clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            last_pop_reg <= 1'b1;
            btn_q_reg    <= '0;
            strobe_reg   <= '0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            last_pop_reg <= last_pop_next;
            btn_q_reg    <= btn;
            strobe_reg   <= strobe_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_pop_next = last_pop_reg;
        fire          = '0;
        unique case (state_reg)
            IDLE: begin
                if (rise[CH_PUSH] && rise[CH_POP]) begin
                    // Simultaneous edges: alternate; the losing edge is dropped.
                    cnt_next      = DELAY_LOAD;
                    last_pop_next = ~last_pop_reg;
                    if (last_pop_reg) begin
                        fire[CH_PUSH] = 1'b1;
                        state_next    = PUSH_HOLD;
                    end else begin
                        fire[CH_POP] = 1'b1;
                        state_next   = POP_HOLD;
                    end
                end else if (rise[CH_PUSH]) begin
                    fire[CH_PUSH] = 1'b1;
                    cnt_next      = DELAY_LOAD;
                    state_next    = PUSH_HOLD;
                end else if (rise[CH_POP]) begin
                    fire[CH_POP] = 1'b1;
                    cnt_next     = DELAY_LOAD;
                    state_next   = POP_HOLD;
                end
            end
            PUSH_HOLD: begin
                if (!btn[CH_PUSH]) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    fire[CH_PUSH] = 1'b1;
                    cnt_next      = RATE_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            POP_HOLD: begin
                if (!btn[CH_POP]) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    fire[CH_POP] = 1'b1;
                    cnt_next     = RATE_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.wr_en   = strobe_reg[CH_PUSH];
    assign bus.rd_en   = strobe_reg[CH_POP];
    assign bus.ovf_err = err_reg[CH_PUSH];
    assign bus.udf_err = err_reg[CH_POP];
    assign bus.state   = state_reg;

endmodule
